// File: rtl/btn_event_port_pkg.sv
// Shared io defines for the button input path: default debounce depth and
// the board button bit order {L,C,R,U} = {3,2,1,0}, also used by dmem_io.
package btn_event_port_pkg;

  localparam int NBTN_DEF      = 4;
  localparam int DB_CYCLES_DEF = 4;
  localparam int CNT_W_DEF     = 3;

  typedef enum int {
    BTN_U = 0,
    BTN_R = 1,
    BTN_C = 2,
    BTN_L = 3
  } btn_idx_e;

endpackage

// File: rtl/btn_event_port_debounce_cell.sv
// One-bit button conditioner: 2-flop synchroniser, then a restartable
// debounce counter. rise is combinational so the parent can capture the
// press on the same edge that the debounced level goes high.
import btn_event_port_pkg::*;

module debounce_cell #(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DB_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // A differing level is accepted on the edge where the count hits terminal.
  assign accept = (s2 != stable) && (cnt == CNT_TC);
  assign rise   = accept & s2;
  assign level  = stable;

  // Synchronise the asynchronous pin; only s1 ever samples raw.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Count consecutive edges of disagreement; any return to stable restarts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (s2 == stable) begin
      cnt <= '0;
    end else if (accept) begin
      stable <= s2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/btn_event_port.sv
// Button input port: per-bit debounce cells plus sticky press/overrun flags
// with an explicit mask clear, so no press is lost between software polls.
import btn_event_port_pkg::*;

module btn_event_port #(
  parameter int NBTN      = NBTN_DEF,
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NBTN-1:0] btn_raw,
  input  logic            clr_en,
  input  logic [NBTN-1:0] clr_mask,
  output logic [NBTN-1:0] btn_level,
  output logic [NBTN-1:0] btn_event,
  output logic [NBTN-1:0] overrun,
  output logic            any_event
);

  logic [NBTN-1:0] rise;
  logic [NBTN-1:0] clr_bits;

  for (genvar i = 0; i < NBTN; i++) begin : g_cell
    debounce_cell #(
      .DB_CYCLES(DB_CYCLES),
      .CNT_W    (CNT_W)
    ) u_cell (
      .clk  (clk),
      .reset(reset),
      .raw  (btn_raw[i]),
      .level(btn_level[i]),
      .rise (rise[i])
    );
  end

  assign clr_bits  = {NBTN{clr_en}} & clr_mask;
  assign any_event = |btn_event;

  // Sticky flags: a rise always wins over a simultaneous clear of its bit,
  // and a rise landing on its own clear is a fresh event, not an overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_event <= '0;
      overrun   <= '0;
    end else begin
      btn_event <= rise | (btn_event & ~clr_bits);
      overrun   <= (rise & btn_event & ~clr_bits) | (overrun & ~clr_bits);
    end
  end

endmodule

// File: tb/tb_btn_event_port.sv
// Scoreboard bench for btn_event_port: stimulus pushes expected output
// snapshots tagged with the clock edge they apply to; a monitor pops and
// compares them after each edge.
module tb_btn_event_port;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_raw;
  logic       clr_en;
  logic [3:0] clr_mask;
  logic [3:0] btn_level;
  logic [3:0] btn_event;
  logic [3:0] overrun;
  logic       any_event;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  typedef struct {
    int         at;
    string      nm;
    logic [3:0] lvl;
    logic [3:0] ev;
    logic [3:0] ov;
  } exp_t;

  exp_t q[$];

  btn_event_port dut (
    .clk      (clk),
    .reset    (reset),
    .btn_raw  (btn_raw),
    .clr_en   (clr_en),
    .clr_mask (clr_mask),
    .btn_level(btn_level),
    .btn_event(btn_event),
    .overrun  (overrun),
    .any_event(any_event)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(string nm, logic [3:0] l, logic [3:0] e, logic [3:0] o);
    logic want_any;
    want_any = |e;
    checks++;
    if ({btn_level, btn_event, overrun, any_event} !== {l, e, o, want_any}) begin
      errors++;
      $display("FAIL %s @edge %0d: got lvl=%b ev=%b ov=%b any=%b, want lvl=%b ev=%b ov=%b any=%b",
               nm, edge_n, btn_level, btn_event, overrun, any_event, l, e, o, want_any);
    end
  endtask

  task automatic ex(int rel, string nm, logic [3:0] l, logic [3:0] e, logic [3:0] o);
    exp_t t;
    t.at  = edge_n + rel;
    t.nm  = nm;
    t.lvl = l;
    t.ev  = e;
    t.ov  = o;
    q.push_back(t);
  endtask

  task automatic ex_span(int from, int to, string nm, logic [3:0] l, logic [3:0] e, logic [3:0] o);
    for (int r = from; r <= to; r++) ex(r, nm, l, e, o);
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: compare every expectation scheduled for the edge just taken.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      while (q.size() > 0 && q[0].at <= edge_n) begin
        e = q.pop_front();
        if (e.at < edge_n) begin
          checks++;
          errors++;
          $display("FAIL %s: expectation for edge %0d not checked (now %0d)", e.nm, e.at, edge_n);
        end else begin
          chk(e.nm, e.lvl, e.ev, e.ov);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no end, want end");
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset    = 1'b1;
    btn_raw  = 4'h0;
    clr_en   = 1'b0;
    clr_mask = 4'h0;
    tick(2);
    chk("reset_state", 4'h0, 4'h0, 4'h0);

    // Held-through-reset: all four buttons down when reset releases.
    reset   = 1'b0;
    btn_raw = 4'hF;
    ex_span(1, 5, "held_pre", 4'h0, 4'h0, 4'h0);
    ex(6, "held_rise", 4'hF, 4'hF, 4'h0);
    tick(8);

    // Test 1: async reset mid-run clears everything immediately.
    @(posedge clk);
    #2 reset = 1'b1;
    #1 chk("reset_async", 4'h0, 4'h0, 4'h0);
    tick(2);
    reset = 1'b0;
    ex_span(1, 5, "t1_pre", 4'h0, 4'h0, 4'h0);
    ex(6, "t1_rise", 4'hF, 4'hF, 4'h0);
    tick(6);

    // Release all: level falls, events stay sticky.
    btn_raw = 4'h0;
    ex(5, "rel_pre", 4'hF, 4'hF, 4'h0);
    ex(6, "rel_fall", 4'h0, 4'hF, 4'h0);
    tick(6);
    clr_en = 1'b1; clr_mask = 4'hF;
    ex(1, "clr_all", 4'h0, 4'h0, 4'h0);
    tick(1);
    clr_en = 1'b0; clr_mask = 4'h0;
    tick(2);

    // Test 2: clean press of bit 1.
    btn_raw = 4'b0010;
    ex_span(1, 5, "t2_pre", 4'h0, 4'h0, 4'h0);
    ex(6, "t2_rise", 4'b0010, 4'b0010, 4'h0);
    tick(6);

    // Test 3: bit 0 bounces every 2 edges for 20 edges, then holds.
    for (int k = 0; k < 10; k++) begin
      btn_raw[0] = ~btn_raw[0];
      ex_span(1, 2, "t3_bounce", 4'b0010, 4'b0010, 4'h0);
      tick(2);
    end
    btn_raw[0] = 1'b1;
    ex_span(1, 5, "t3_hold_pre", 4'b0010, 4'b0010, 4'h0);
    ex(6, "t3_hold_rise", 4'b0011, 4'b0011, 4'h0);
    tick(6);

    // Test 4: bit 2 re-press coincides with its own clear.
    btn_raw = 4'b0111;
    ex(6, "t4_first", 4'b0111, 4'b0111, 4'h0);
    tick(6);
    btn_raw = 4'b0011;
    ex(6, "t4_release", 4'b0011, 4'b0111, 4'h0);
    tick(6);
    btn_raw = 4'b0111;
    ex(5, "t4_pre", 4'b0011, 4'b0111, 4'h0);
    ex(6, "t4_set_vs_clr", 4'b0111, 4'b0111, 4'h0);
    tick(5);
    clr_en = 1'b1; clr_mask = 4'b0100;
    tick(1);
    // Clearing an already-clear bit and an empty mask are both no-ops.
    clr_mask = 4'b1000;
    ex(1, "clr_noop_bit", 4'b0111, 4'b0111, 4'h0);
    tick(1);
    clr_mask = 4'b0000;
    ex(1, "clr_noop_mask", 4'b0111, 4'b0111, 4'h0);
    tick(1);
    clr_en = 1'b0;

    // Test 5: overrun on bit 3.
    btn_raw = 4'b1111;
    ex(6, "t5_first", 4'b1111, 4'b1111, 4'h0);
    tick(6);
    btn_raw = 4'b0111;
    ex(6, "t5_release", 4'b0111, 4'b1111, 4'h0);
    tick(6);
    btn_raw = 4'b1111;
    ex(6, "t5_overrun", 4'b1111, 4'b1111, 4'b1000);
    tick(6);
    clr_en = 1'b1; clr_mask = 4'b1000;
    ex(1, "t5_clr", 4'b1111, 4'b0111, 4'h0);
    tick(1);
    clr_mask = 4'b0111;
    ex(1, "t5_clr_rest", 4'b1111, 4'h0, 4'h0);
    tick(1);
    clr_en = 1'b0; clr_mask = 4'h0;

    // Test 6: reset lands mid-debounce of bit 2.
    btn_raw = 4'h0;
    ex(6, "t6_idle", 4'h0, 4'h0, 4'h0);
    tick(8);
    btn_raw = 4'b0100;
    ex_span(1, 3, "t6_pre_rst", 4'h0, 4'h0, 4'h0);
    tick(3);
    reset = 1'b1;
    ex_span(1, 4, "t6_in_rst", 4'h0, 4'h0, 4'h0);
    tick(4);
    reset = 1'b0;
    ex_span(1, 5, "t6_post_pre", 4'h0, 4'h0, 4'h0);
    ex(6, "t6_post_rise", 4'b0100, 4'b0100, 4'h0);
    tick(8);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
